// File: rtl/display_pkg.sv
// Shared definitions for the Apple-1 display output path: character codes,
// FSM state encodings and the CR-expansion decision.
package display_pkg;

  localparam logic [6:0] CHR_CR = 7'h0D;
  localparam logic [6:0] CHR_LF = 7'h0A;

  typedef enum logic [2:0] {
    C_IDLE,
    C_PUSH,
    C_PUSH_LF,
    C_ACK,
    C_WAIT
  } cap_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD
  } wr_state_t;

  // True when a captured character occupies two queue slots (CR followed by LF).
  function automatic logic expands(input logic [6:0] chr, input logic crlf_en);
    return crlf_en && (chr == CHR_CR);
  endfunction

endpackage

// File: rtl/chr_fifo.sv
// DEPTH x W character queue, registered count/free; head visible combinationally.
// Push and pop may share a cycle when non-empty; pushes to a full queue are ignored.
module chr_fifo
  import display_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   free_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign free_o     = DEPTH_C - count_q;
  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/display_tx.sv
// PIA port-B characters -> FT245 writes; ack ~4 clk after push, write every 1+WR+HOLD+1 clk.
// Ack to the CPU is withheld until the queue has room, so characters are never dropped.
module display_tx
  import display_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CRLF        = 1,
  parameter int WR_CYCLES   = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int ACK_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pia_cb2,
  input  logic [6:0] pia_pb,
  output logic       pia_cb1,
  input  logic       fifo_txe,
  output logic       fifo_wr,
  output logic [6:0] fifo_wd,
  output logic       fifo_oe,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 8;
  localparam logic [AW:0]   TWO_SLOTS = (AW+1)'(2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic cb2_s1_q, cb2_s2_q, cb2_s3_q;
  logic txe_s1_q, txe_s2_q;
  logic cb2_rise;

  cap_state_t    cap_q, cap_d;
  logic [6:0]    chr_q, chr_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic          cb1_q;

  wr_state_t     wst_q, wst_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [6:0]    wd_q, wd_d;
  logic          wr_q, oe_q;

  logic          push, pop;
  logic [6:0]    push_dat, head_dat;
  logic [AW:0]   count, free;
  logic          full, empty;
  logic          needs_two, room;

  chr_fifo #(
    .DEPTH (DEPTH),
    .W     (7)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (count),
    .free_o     (free),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Request edge is taken after the second synchroniser flop.
  assign cb2_rise  = cb2_s2_q && !cb2_s3_q;
  assign needs_two = expands(chr_q, CRLF != 0);
  assign room      = needs_two ? (free >= TWO_SLOTS) : !full;

  always_comb begin
    cap_d     = cap_q;
    chr_d     = chr_q;
    ack_cnt_d = ack_cnt_q;
    push      = 1'b0;
    push_dat  = chr_q;
    case (cap_q)
      C_IDLE: begin
        if (cb2_rise) begin
          chr_d = pia_pb;
          cap_d = C_PUSH;
        end
      end
      C_PUSH: begin
        if (room) begin
          push      = 1'b1;
          ack_cnt_d = '0;
          cap_d     = needs_two ? C_PUSH_LF : C_ACK;
        end
      end
      C_PUSH_LF: begin
        push      = 1'b1;
        push_dat  = CHR_LF;
        ack_cnt_d = '0;
        cap_d     = C_ACK;
      end
      C_ACK: begin
        if (ack_cnt_q == ACK_LAST) cap_d = C_WAIT;
        else                       ack_cnt_d = ack_cnt_q + CNT_ONE;
      end
      C_WAIT: begin
        if (!cb2_s2_q) cap_d = C_IDLE;
      end
      default: cap_d = C_IDLE;
    endcase
  end

  // txe is sampled only here; once a write starts it runs to completion.
  always_comb begin
    wst_d    = wst_q;
    wr_cnt_d = wr_cnt_q;
    wd_d     = wd_q;
    pop      = 1'b0;
    case (wst_q)
      W_IDLE: begin
        if (!empty && !txe_s2_q) begin
          pop   = 1'b1;
          wd_d  = head_dat;
          wst_d = W_SETUP;
        end
      end
      W_SETUP: begin
        wr_cnt_d = '0;
        wst_d    = W_STROBE;
      end
      W_STROBE: begin
        if (wr_cnt_q == WR_LAST) begin
          wr_cnt_d = '0;
          wst_d    = W_HOLD;
        end else begin
          wr_cnt_d = wr_cnt_q + CNT_ONE;
        end
      end
      W_HOLD: begin
        if (wr_cnt_q == HOLD_LAST) wst_d = W_IDLE;
        else                       wr_cnt_d = wr_cnt_q + CNT_ONE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cb2_s1_q  <= 1'b0;
      cb2_s2_q  <= 1'b0;
      cb2_s3_q  <= 1'b0;
      txe_s1_q  <= 1'b0;
      txe_s2_q  <= 1'b0;
      cap_q     <= C_IDLE;
      chr_q     <= '0;
      ack_cnt_q <= '0;
      cb1_q     <= 1'b0;
      wst_q     <= W_IDLE;
      wr_cnt_q  <= '0;
      wd_q      <= '0;
      wr_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      cb2_s1_q  <= pia_cb2;
      cb2_s2_q  <= cb2_s1_q;
      cb2_s3_q  <= cb2_s2_q;
      txe_s1_q  <= fifo_txe;
      txe_s2_q  <= txe_s1_q;
      cap_q     <= cap_d;
      chr_q     <= chr_d;
      ack_cnt_q <= ack_cnt_d;
      // Strobes are registered from next state so the async pins never glitch.
      cb1_q     <= (cap_d == C_ACK);
      wst_q     <= wst_d;
      wr_cnt_q  <= wr_cnt_d;
      wd_q      <= wd_d;
      wr_q      <= (wst_d == W_STROBE);
      oe_q      <= (wst_d != W_IDLE);
    end
  end

  assign pia_cb1 = cb1_q;
  assign fifo_wr = wr_q;
  assign fifo_oe = oe_q;
  assign fifo_wd = wd_q;
  assign busy    = (count != '0) || (wst_q != W_IDLE);

endmodule
